// File: rtl/magic_packet_injector.sv
// Turns free environment push/pop requests into legal FIFO traffic and tags one
// "magic" packet, tracking how many older entries sit ahead of it until it pops.
module magic_packet_injector #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int CNTWID = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic              req_start,
  input  logic [WIDTH-1:0]  req_data,
  output logic              push,
  output logic              pop,
  output logic              start,
  output logic [WIDTH-1:0]  data_in,
  output logic [CNTWID-1:0] occ,
  output logic [1:0]        state,
  output logic [WIDTH-1:0]  magic_packet,
  output logic              magic_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [CNTWID-1:0] FULL = CNTWID'(DEPTH);

  state_t            state_q, state_d;
  logic [CNTWID-1:0] occ_q, occ_d;
  logic [CNTWID-1:0] ahead_q, ahead_d;
  logic [WIDTH-1:0]  magic_q, magic_d;
  logic [CNTWID-1:0] push_ext, pop_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      occ_q   <= '0;
      ahead_q <= '0;
      magic_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ahead_q <= ahead_d;
      magic_q <= magic_d;
    end
  end

  always_comb begin
    push      = !rst && req_push && (occ_q != FULL);
    pop       = !rst && req_pop && (occ_q != '0);
    start     = !rst && req_start && push && (state_q == IDLE);
    magic_out = pop && (state_q == INFLIGHT) && (ahead_q == '0);
    push_ext  = {{(CNTWID-1){1'b0}}, push};
    pop_ext   = {{(CNTWID-1){1'b0}}, pop};
    occ_d     = occ_q + push_ext - pop_ext;
    state_d   = state_q;
    ahead_d   = ahead_q;
    magic_d   = magic_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INFLIGHT;
          magic_d = req_data;
          // a same-cycle pop removes one of the older entries
          ahead_d = occ_q - pop_ext;
        end
      end
      INFLIGHT: begin
        if (pop) begin
          if (ahead_q == '0) state_d = DONE;
          else               ahead_d = ahead_q - 1'b1;
        end
      end
      default: ;  // DONE and the unused encoding are both terminal
    endcase
  end

  assign data_in      = req_data;
  assign occ          = occ_q;
  assign state        = state_q;
  assign magic_packet = magic_q;

endmodule

// File: tb/tb_magic_packet_injector.sv
// Scoreboard bench: a queue-of-packets model predicts each cycle's outputs; a
// separate monitor compares them against the DUT on the falling clock edge.
module tb_magic_packet_injector;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_push = 1'b0, req_pop = 1'b0, req_start = 1'b0;
  logic [WIDTH-1:0] req_data = '0;
  logic             push, pop, start, magic_out;
  logic [WIDTH-1:0] data_in, magic_packet;
  logic [3:0]       occ;
  logic [1:0]       state;

  magic_packet_injector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_push(req_push), .req_pop(req_pop),
    .req_start(req_start), .req_data(req_data), .push(push), .pop(pop),
    .start(start), .data_in(data_in), .occ(occ), .state(state),
    .magic_packet(magic_packet), .magic_out(magic_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             push, pop, start, magic_out;
    int               occ, state;
    logic [WIDTH-1:0] magic, data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: FIFO contents as a queue, bit WIDTH marks the magic entry
  logic [WIDTH:0]   fifo_m[$];
  int               st_m = 0;
  logic [WIDTH-1:0] magic_m = '0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic cycle(input logic rp, input logic rpo, input logic rs,
                       input logic [WIDTH-1:0] d, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req_push = rp; req_pop = rpo; req_start = rs; req_data = d;
    e.data = d;
    if (r) begin
      fifo_m.delete();
      st_m = 0;
      magic_m = '0;
      e.push = 0; e.pop = 0; e.start = 0; e.magic_out = 0;
      e.occ = 0; e.state = 0; e.magic = '0;
    end else begin
      e.occ       = fifo_m.size();
      e.state     = st_m;
      e.magic     = magic_m;
      e.push      = rp && (fifo_m.size() < DEPTH);
      e.pop       = rpo && (fifo_m.size() > 0);
      e.start     = rs && e.push && (st_m == 0);
      e.magic_out = e.pop && fifo_m[0][WIDTH];
      if (e.pop) void'(fifo_m.pop_front());
      if (e.push) fifo_m.push_back({e.start, d});
      if (e.start) begin st_m = 1; magic_m = d; end
      if (e.magic_out) st_m = 2;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("push", int'(push), int'(e.push));
        chk("pop", int'(pop), int'(e.pop));
        chk("start", int'(start), int'(e.start));
        chk("magic_out", int'(magic_out), int'(e.magic_out));
        chk("occ", int'(occ), e.occ);
        chk("state", int'(state), e.state);
        chk("magic_packet", int'(magic_packet), int'(e.magic));
        chk("data_in", int'(data_in), int'(e.data));
      end
    end
  end

  initial begin : stim
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);
    repeat (3) cycle(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 8'(i + 1), 0);
    // injection behind three older packets
    cycle(0, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 8'h11, 0);
    cycle(1, 0, 0, 8'h22, 0);
    cycle(1, 0, 0, 8'h33, 0);
    cycle(1, 0, 1, 8'hA5, 0);
    repeat (4) cycle(0, 1, 0, 8'h00, 0);
    cycle(0, 0, 0, 8'h00, 0);
    // injection into an empty FIFO with a blocked pop
    cycle(0, 0, 0, 8'h00, 1);
    cycle(1, 1, 1, 8'h5C, 0);
    cycle(0, 1, 0, 8'h00, 0);
    cycle(1, 0, 1, 8'h77, 0);
    cycle(0, 0, 0, 8'h00, 0);
    // full FIFO with simultaneous requests
    cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 8'(8'h40 + i), 0);
    cycle(1, 1, 0, 8'h90, 0);
    cycle(1, 1, 0, 8'h91, 0);
    // async reset while in flight with five entries
    cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 8'(8'h60 + i), 0);
    cycle(1, 0, 1, 8'hC3, 0);
    cycle(1, 1, 0, 8'h00, 1);
    cycle(1, 0, 1, 8'h3C, 0);
    cycle(0, 1, 0, 8'h00, 0);
    // randomized traffic, occasional resets so injection recurs
    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 8), 8'($urandom),
            1'($urandom_range(0, 199) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/magic_packet_injector.md
# magic_packet_injector

- Transmit-side counterpart of the FIFO data-integrity scoreboard.
- Turns free (unconstrained) environment requests into legal FIFO push/pop traffic and injects exactly one tagged "magic" packet, recording its value.
- Tracks how many older packets are ahead of the magic packet and flags the cycle it leaves the FIFO.
- Sits between the formal/random environment and the FIFO under test, beside the scoreboard.

## Interface
Parameters:
- DEPTH, 8, FIFO capacity in entries (≥2).
- WIDTH, 8, packet data width.
- CNTWID, $clog2(DEPTH+1), occupancy/ahead counter width; must be able to hold the value DEPTH.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req_push  input  1  environment request to push.
- req_pop  input  1  environment request to pop.
- req_start  input  1  request to tag the current push as the magic packet.
- req_data  input  WIDTH  candidate packet data.
- push  output  1  legal push to FIFO.
- pop  output  1  legal pop to FIFO.
- start  output  1  magic-packet injection strobe to the scoreboard.
- data_in  output  WIDTH  FIFO write data; equals req_data.
- occ  output  CNTWID  registered FIFO occupancy.
- state  output  2  FSM state: 0 IDLE, 1 INFLIGHT, 2 DONE.
- magic_packet  output  WIDTH  captured magic value.
- magic_out  output  1  magic packet is being popped this cycle.

## Operation
- Combinational gating, all forced to 0 while rst=1:
  - push = req_push & (occ != DEPTH).
  - pop = req_pop & (occ != 0).
  - start = req_start & push & (state == IDLE).
  - magic_out = pop & (state == INFLIGHT) & (ahead == 0).
- At full, push is blocked even if pop is granted in the same cycle.
- At empty, pop is blocked even if push is granted in the same cycle.
- Occupancy update: occ_next = occ + push − pop. It never exceeds DEPTH and never underflows.
- Internal `ahead` register (CNTWID bits) holds the number of packets in front of the magic packet.
- FSM:
  - IDLE → INFLIGHT when start=1.
    - magic_packet <= req_data.
    - ahead <= occ − pop: a same-cycle pop removes an older packet.
  - INFLIGHT, pop=1 and ahead>0: ahead <= ahead − 1. State holds.
  - INFLIGHT, pop=1 and ahead==0: magic_out=1, → DONE.
  - DONE: sticky until reset. start is never asserted again. push/pop gating continues normally.
  - Encoding 3 is unreachable. If entered, it behaves as DONE.
- magic_packet and ahead change only on the IDLE→INFLIGHT transition and on INFLIGHT pops.
- Integrity contract: in any cycle with magic_out=1, the FIFO's data_out must equal magic_packet. The scoreboard's data_out_vld must coincide with magic_out.

## Timing
- Reset (async, immediate on rst rise): occ=0, state=IDLE, ahead=0, magic_packet=0. push/pop/start/magic_out=0. data_in follows req_data.
- Registered outputs (occ, state, magic_packet) update on the clk rising edge after the qualifying cycle.
- Combinational outputs (push, pop, start, magic_out) are Mealy outputs, valid in the same cycle as the requests.
- Latency:
  - The magic packet exits on the (k+1)-th granted pop after injection, where k is the value of ahead after injection.
  - Minimum one cycle after injection, when injected into an empty FIFO.
- Reset mid-operation: all state is discarded and injection may recur after reset deasserts.

## Test plan
- Reset, then req_pop=1 for 3 cycles → pop=0 each cycle, occ stays 0, state=IDLE.
- req_push=1 for 10 cycles, no pops → push=1 for the first 8 cycles, then 0; occ saturates at 8.
- Push 0x11, 0x22, 0x33. Then req_start+req_push with data 0xA5 → start=1, state=INFLIGHT, magic_packet=0xA5, ahead=3.
  - Three pops → magic_out=0 on each.
  - Fourth pop → magic_out=1, state=DONE next cycle.
- Empty FIFO, same cycle req_start+req_push (0x5C) and req_pop → pop=0, ahead=0.
  - Next cycle req_pop → pop=1, magic_out=1.
  - A later req_start+req_push → start=0.
- Full FIFO (occ=8) with req_push=req_pop=1 → push=0, pop=1, occ 8→7.
  - Next cycle both requests again → push=1, pop=1, occ stays 7.
- Assert rst asynchronously while INFLIGHT with occ=5 → before the next clk edge: occ=0, state=IDLE, magic_packet=0, push/pop=0.
